// File: rtl/multdiv_issue_ctrl.sv
// multdiv_issue_ctrl: holds one MULT/DIV in execute, pulses multdiv once, writes back the result or an exception code.
// Latency: start pulse in the cycle after accept; write-back beat one cycle after data_resultRDY or after TIMEOUT wait cycles.
// Backpressure: stall freezes execute from accept through WAIT and drops in DONE so the instruction retires on that edge.
module multdiv_issue_ctrl #(
  parameter int          TIMEOUT       = 40,
  parameter logic [4:0]  RSTATUS_REG   = 5'd30,
  parameter logic [31:0] MULT_EXC_CODE = 32'd4,
  parameter logic [31:0] DIV_EXC_CODE  = 32'd5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_is_mult,
  input  logic        req_is_div,
  input  logic [31:0] req_operandA,
  input  logic [31:0] req_operandB,
  input  logic [4:0]  req_rd,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic [31:0] md_operandA,
  output logic [31:0] md_operandB,
  output logic        md_ctrl_MULT,
  output logic        md_ctrl_DIV,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_exception,
  output logic        err_timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  // Latched instruction context (op type and destination).
  typedef struct packed {
    logic       is_mult;
    logic [4:0] rd;
  } op_t;

  // Write-back beat contents.
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        exc;
  } wb_t;

  state_t        state, state_nxt;
  logic [CW-1:0] wait_cnt;
  op_t           op_q;
  wb_t           wb_q;
  logic          accept;
  logic          timeout_hit;
  logic          capture;
  logic [31:0]   exc_code;

  // A request is taken only from IDLE; flush in IDLE blocks it.
  assign accept      = (state == S_IDLE) & req_valid & (req_is_mult | req_is_div) & ~flush;
  // Last allowed WAIT cycle without resultRDY forces completion.
  assign timeout_hit = (state == S_WAIT) & ~md_resultRDY & (wait_cnt == CW'(TIMEOUT - 1));
  // Leaving WAIT towards DONE (flush has priority over completion).
  assign capture     = (state == S_WAIT) & ~flush & (md_resultRDY | timeout_hit);
  assign exc_code    = op_q.is_mult ? MULT_EXC_CODE : DIV_EXC_CODE;

  assign wb_rd        = wb_q.rd;
  assign wb_data      = wb_q.data;
  assign wb_exception = wb_q.exc;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and combinational outputs.
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    busy      = 1'b1;
    wb_valid  = 1'b0;
    case (state)
      S_IDLE: begin
        busy  = 1'b0;
        stall = accept;
        if (accept) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        // resultRDY here still belongs to the previous operation.
        stall     = 1'b1;
        state_nxt = flush ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        stall = 1'b1;
        if (flush)        state_nxt = S_IDLE;
        else if (capture) state_nxt = S_DONE;
      end
      S_DONE: begin
        wb_valid  = ~flush;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand/op latch on accept and the one-cycle start pulse; MULT wins if both op bits are set.
  always_ff @(posedge clock) begin
    if (reset) begin
      md_operandA  <= '0;
      md_operandB  <= '0;
      md_ctrl_MULT <= 1'b0;
      md_ctrl_DIV  <= 1'b0;
      op_q         <= '0;
    end else begin
      md_ctrl_MULT <= accept & req_is_mult;
      md_ctrl_DIV  <= accept & ~req_is_mult;
      if (accept) begin
        md_operandA  <= req_operandA;
        md_operandB  <= req_operandB;
        op_q.is_mult <= req_is_mult;
        op_q.rd      <= req_rd;
      end
    end
  end

  // Wait counter: cleared in ISSUE, counts every WAIT cycle.
  always_ff @(posedge clock) begin
    if (reset)                  wait_cnt <= '0;
    else if (state == S_ISSUE)  wait_cnt <= '0;
    else if (state == S_WAIT)   wait_cnt <= wait_cnt + 1'b1;
  end

  // Write-back capture and sticky timeout flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      wb_q        <= '0;
      err_timeout <= 1'b0;
    end else if (capture) begin
      if (md_resultRDY && !md_exception) begin
        wb_q.rd   <= op_q.rd;
        wb_q.data <= md_result;
        wb_q.exc  <= 1'b0;
      end else begin
        wb_q.rd   <= RSTATUS_REG;
        wb_q.data <= exc_code;
        wb_q.exc  <= 1'b1;
      end
      if (timeout_hit) err_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// tb_multdiv_issue_ctrl: drives MULT/DIV requests against a latency-accurate multdiv stub and scoreboards write-backs.
// Latency: expected write-back cycle is queued at accept and compared when wb_valid appears.
// Backpressure: requests are held in execute while stall is high and withdrawn in the retire cycle.
module tb_multdiv_issue_ctrl;

  localparam int MUL_LAT = 19;
  localparam int DIV_LAT = 35;
  localparam int TO_LAT  = 42;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_is_mult, req_is_div;
  logic [31:0] req_operandA, req_operandB;
  logic [4:0]  req_rd;
  logic        flush;
  logic        stall, busy;
  logic [31:0] md_operandA, md_operandB;
  logic        md_ctrl_MULT, md_ctrl_DIV;
  logic [31:0] md_result = '0;
  logic        md_exception = 1'b0;
  logic        md_resultRDY = 1'b0;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_exception;
  logic        err_timeout;

  multdiv_issue_ctrl dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_is_mult(req_is_mult), .req_is_div(req_is_div),
    .req_operandA(req_operandA), .req_operandB(req_operandB), .req_rd(req_rd),
    .flush(flush), .stall(stall), .busy(busy),
    .md_operandA(md_operandA), .md_operandB(md_operandB),
    .md_ctrl_MULT(md_ctrl_MULT), .md_ctrl_DIV(md_ctrl_DIV),
    .md_result(md_result), .md_exception(md_exception), .md_resultRDY(md_resultRDY),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_exception(wb_exception),
    .err_timeout(err_timeout)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        exc;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   pulse_cnt = 0;
  logic stub_mute = 1'b0;
  int   stub_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Arithmetic the multdiv unit performs: returns {exception, result}.
  function automatic logic [32:0] md_math(input logic is_mult, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, p;
    logic signed [31:0] q;
    if (is_mult) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      p  = sa * sb;
      return {(p != {{32{p[31]}}, p[31:0]}), p[31:0]};
    end
    if (b == 32'd0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return {1'b1, 32'd0};
    q = $signed(a) / $signed(b);
    return {1'b0, q};
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  // multdiv stub: result after 17 (MULT) / 33 (DIV) cycles, RDY then held until the next start.
  always @(posedge clock) begin
    if (reset) begin
      md_resultRDY <= 1'b0;
      stub_cnt     <= 0;
    end else if (md_ctrl_MULT || md_ctrl_DIV) begin
      {md_exception, md_result} <= md_math(md_ctrl_MULT, md_operandA, md_operandB);
      md_resultRDY <= 1'b0;
      stub_cnt     <= md_ctrl_MULT ? 16 : 32;
    end else if (stub_cnt > 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1 && !stub_mute) md_resultRDY <= 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every write-back beat, counts start pulses.
  always @(negedge clock) begin
    if (md_ctrl_MULT || md_ctrl_DIV) begin
      pulse_cnt++;
      check("ctrl_onehot", 32'(md_ctrl_MULT & md_ctrl_DIV), 32'd0);
    end
    if (wb_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("wb_unexpected", 32'(wb_valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("wb_rd", 32'(wb_rd), 32'(e.rd));
        check("wb_data", wb_data, e.data);
        check("wb_exception", 32'(wb_exception), 32'(e.exc));
        check("wb_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (busy === 1'b0) return;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic clear_req();
    req_valid   = 1'b0;
    req_is_mult = 1'b0;
    req_is_div  = 1'b0;
  endtask

  // abort: 0 none, 1 flush at cycle acc+abort_at, 2 reset at cycle acc+abort_at, 3 flush in DONE.
  task automatic do_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit toggle, input int abort, input int abort_at);
    int          acc, lat, p0;
    logic        eff_mult;
    logic [32:0] r;
    exp_t        e;
    wait_idle();
    eff_mult     = m;
    lat          = stub_mute ? TO_LAT : (eff_mult ? MUL_LAT : DIV_LAT);
    req_valid    = 1'b1;
    req_is_mult  = m;
    req_is_div   = d;
    req_operandA = a;
    req_operandB = b;
    req_rd       = rd;
    acc          = cyc;
    p0           = pulse_cnt;
    #1;
    check("stall_accept", 32'(stall), 32'd1);
    if (abort == 0) begin
      r = md_math(eff_mult, a, b);
      if (stub_mute || r[32]) e = '{5'd30, (eff_mult ? 32'd4 : 32'd5), 1'b1, acc + lat};
      else                    e = '{rd, r[31:0], 1'b0, acc + lat};
      exp_q.push_back(e);
    end
    for (int k = 1; k <= lat; k++) begin
      @(negedge clock);
      if (k == 1) begin
        check("pulse_mult", 32'(md_ctrl_MULT), 32'(eff_mult));
        check("pulse_div", 32'(md_ctrl_DIV), 32'(!eff_mult));
      end
      if (abort == 1 && k == abort_at) begin
        flush = 1'b1;
        clear_req();
        @(negedge clock);
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_stall", 32'(stall), 32'd0);
        flush = 1'b0;
        check("flush_pulses", pulse_cnt - p0, 32'd1);
        return;
      end
      if (abort == 2 && k == abort_at) begin
        reset = 1'b1;
        clear_req();
        @(negedge clock);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_opA", md_operandA, 32'd0);
        check("rst_opB", md_operandB, 32'd0);
        check("rst_ctrl", 32'({md_ctrl_MULT, md_ctrl_DIV}), 32'd0);
        check("rst_wb", 32'({wb_valid, wb_rd, wb_exception}), 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_err_timeout", 32'(err_timeout), 32'd0);
        reset = 1'b0;
        p0 = pulse_cnt;
        repeat (40) @(negedge clock);
        check("rst_no_pulse", pulse_cnt - p0, 32'd0);
        return;
      end
      if (k < lat) begin
        check("stall_hold", 32'(stall), 32'd1);
        check("hold_opA", md_operandA, a);
        check("hold_opB", md_operandB, b);
        if (toggle) begin
          req_operandA = $urandom;
          req_operandB = $urandom;
        end
        if (abort == 3 && k == lat - 1) begin
          @(posedge clock);
          #1 flush = 1'b1;
          @(negedge clock);
          check("done_flush_wb", 32'(wb_valid), 32'd0);
          check("done_flush_busy", 32'(busy), 32'd1);
          clear_req();
          @(posedge clock);
          #1 flush = 1'b0;
          return;
        end
      end else begin
        check("stall_done", 32'(stall), 32'd0);
        check("busy_done", 32'(busy), 32'd1);
        clear_req();
      end
    end
    check("pulse_count", pulse_cnt - p0, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    clear_req();
    req_operandA = '0;
    req_operandB = '0;
    req_rd       = '0;
    repeat (3) @(negedge clock);
    check("reset_stall_busy", 32'({stall, busy}), 32'd0);
    check("reset_opA", md_operandA, 32'd0);
    check("reset_opB", md_operandB, 32'd0);
    check("reset_ctrl", 32'({md_ctrl_MULT, md_ctrl_DIV}), 32'd0);
    check("reset_wb", 32'({wb_valid, wb_rd, wb_exception}), 32'd0);
    check("reset_wb_data", wb_data, 32'd0);
    check("reset_err_timeout", 32'(err_timeout), 32'd0);
    reset = 1'b0;

    do_op(1'b1, 1'b0, 32'd7, -32'sd6, 5'd5, 1'b0, 0, 0);
    do_op(1'b0, 1'b1, -32'sd100, 32'd7, 5'd9, 1'b1, 0, 0);
    do_op(1'b0, 1'b1, 32'd1234, 32'd0, 5'd9, 1'b0, 0, 0);
    do_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 5'd12, 1'b0, 0, 0);

    // flush in IDLE must block accept.
    @(negedge clock);
    req_valid = 1'b1; req_is_mult = 1'b1; flush = 1'b1;
    #1 check("idle_flush_stall", 32'(stall), 32'd0);
    @(negedge clock);
    check("idle_flush_busy", 32'(busy), 32'd0);
    clear_req();
    flush = 1'b0;

    do_op(1'b1, 1'b0, 32'd11, 32'd13, 5'd4, 1'b0, 1, 11);
    do_op(1'b1, 1'b0, 32'd3, 32'd4, 5'd7, 1'b0, 0, 0);
    do_op(1'b1, 1'b1, 32'd6, 32'd9, 5'd8, 1'b0, 0, 0);
    do_op(1'b0, 1'b1, 32'd50, 32'd5, 5'd2, 1'b0, 3, 0);

    check("err_timeout_before", 32'(err_timeout), 32'd0);
    stub_mute = 1'b1;
    do_op(1'b1, 1'b0, 32'd2, 32'd3, 5'd3, 1'b0, 0, 0);
    stub_mute = 1'b0;
    check("err_timeout_set", 32'(err_timeout), 32'd1);
    do_op(1'b0, 1'b1, 32'd81, 32'd9, 5'd6, 1'b0, 0, 0);
    check("err_timeout_sticky", 32'(err_timeout), 32'd1);

    for (int n = 0; n < 20; n++) begin
      logic [31:0] a, b;
      logic        m;
      m = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : (($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 1000)));
      repeat ($urandom_range(0, 2)) @(negedge clock);
      do_op(m, ~m, a, b, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 0, 0);
    end

    do_op(1'b0, 1'b1, 32'd77, 32'd7, 5'd10, 1'b0, 2, 10);
    do_op(1'b1, 1'b0, 32'd5, 32'd5, 5'd0, 1'b0, 0, 0);

    repeat (5) @(negedge clock);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
